// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encodings
// reused by the serial subtractor and future serial adder/multiplier units.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter width able to hold 0..width inclusive.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fa.sv
// Single-bit full adder slice built from gate-level equations; the one
// arithmetic element the serial subtractor iterates over.
module fa_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign sum     = a_xor_b ^ cin;
  assign cout    = (a & b) | (cin & a_xor_b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, LSB first,
// one bit per clock through a single full-adder slice with a registered carry.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             b_inv, sum, cout;
  logic             last_bit;

  // Subtraction is addition of the inverted subtrahend; the +1 comes from
  // carry being preset to 1 when an operation is accepted.
  assign b_inv = ~b_sr[0];

  fa_structural u_fa (
    .a    (a_sr[0]),
    .b    (b_inv),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  assign last_bit = (cnt == LAST);

  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_next = sum;
    end else begin : g_diff_wn
      assign diff_next = {sum, diff[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b1;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          diff  <= diff_next;
          carry <= cout;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          // No carry out of the top bit means the subtrahend was larger.
          if (last_bit) borrow <= ~cout;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor;

  typedef struct packed {
    logic       borrow;
    logic [7:0] diff;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow;
  logic [7:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  res_t       sb[$];
  logic [4:0] sb4[$];

  logic [7:0] bb_a[6] = '{8'd200, 8'd3, 8'd77, 8'd0, 8'd255, 8'd128};
  logic [7:0] bb_b[6] = '{8'd55, 8'd10, 8'd77, 8'd1, 8'd0, 8'd129};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
  );

  // One operation on the WIDTH=8 instance; optionally pulses a spurious
  // start (a=1, b=2) once busy_cnt reaches inject_at.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input int inject_at);
    res_t exp, got;
    int   busy_cnt;
    logic seen;
    @(negedge clk);
    start = 1'b1; a = op_a; b = op_b;
    sb.push_back({op_a < op_b, 8'(op_a - op_b)});
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    busy_cnt = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (inject_at > 0 && busy && busy_cnt == inject_at) begin
        start = 1'b1; a = 8'd1; b = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp = sb.pop_front();
    total_cnt++;
    if (!seen) $display("FAIL done_timeout a=%0d b=%0d: done not seen within 20 cycles", op_a, op_b);
    else pass_cnt++;
    if (seen) begin
      total_cnt++;
      if (busy_cnt !== 8) $display("FAIL busy_len a=%0d b=%0d: got %0d cycles, want 8", op_a, op_b, busy_cnt);
      else pass_cnt++;
      got = {borrow, diff};
      total_cnt++;
      if (got !== exp)
        $display("FAIL result a=%0d b=%0d: got diff=%h borrow=%b, want diff=%h borrow=%b",
                 op_a, op_b, got.diff, got.borrow, exp.diff, exp.borrow);
      else pass_cnt++;
      @(negedge clk);
      got = {borrow, diff};
      total_cnt++;
      if (got !== exp || done !== 1'b0)
        $display("FAIL hold a=%0d b=%0d: got diff=%h borrow=%b done=%b, want diff=%h borrow=%b done=0",
                 op_a, op_b, got.diff, got.borrow, done, exp.diff, exp.borrow);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({busy, done, borrow, diff} !== 11'd0 || {busy4, done4, borrow4, diff4} !== 7'd0)
      $display("FAIL reset_state: got busy=%b done=%b borrow=%b diff=%h, want all 0", busy, done, borrow, diff);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, borrow, diff} !== 11'd0)
      $display("FAIL idle_after_reset: got busy=%b done=%b borrow=%b diff=%h, want all 0", busy, done, borrow, diff);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_op(8'd100, 8'd37, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd0, 8'd0, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'd0, 8'd1, 0);
  endtask

  task automatic test_start_ignored();
    run_op(8'd100, 8'd37, 3);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd37;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_before_abort: got %b, want 1", busy);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, borrow, diff} !== 11'd0)
      $display("FAIL abort_outputs: got busy=%b done=%b borrow=%b diff=%h, want all 0", busy, done, borrow, diff);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL no_done_after_abort: got %0d pulses, want 0", done_cnt);
    else pass_cnt++;
    run_op(8'd20, 8'd7, 0);
  endtask

  task automatic test_back_to_back();
    int   idx, last_done, got_cnt;
    res_t exp, got;
    @(negedge clk);
    start = 1'b1; a = bb_a[0]; b = bb_b[0];
    sb.push_back({bb_a[0] < bb_b[0], 8'(bb_a[0] - bb_b[0])});
    idx = 1;
    last_done = -1;
    got_cnt = 0;
    for (int cyc = 0; cyc < 100 && got_cnt < 6; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) begin
          total_cnt++;
          if (cyc - last_done !== 10)
            $display("FAIL b2b_period op%0d: got %0d cycles, want 10", got_cnt, cyc - last_done);
          else pass_cnt++;
        end
        last_done = cyc;
        exp = sb.pop_front();
        got = {borrow, diff};
        total_cnt++;
        if (got !== exp)
          $display("FAIL b2b_result op%0d: got diff=%h borrow=%b, want diff=%h borrow=%b",
                   got_cnt, got.diff, got.borrow, exp.diff, exp.borrow);
        else pass_cnt++;
        got_cnt++;
        if (idx < 6) begin
          a = bb_a[idx]; b = bb_b[idx];
          sb.push_back({bb_a[idx] < bb_b[idx], 8'(bb_a[idx] - bb_b[idx])});
          idx++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total_cnt++;
    if (got_cnt !== 6) $display("FAIL b2b_count: got %0d results, want 6", got_cnt);
    else pass_cnt++;
    sb.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_sweep_w4();
    logic [3:0] va, vb;
    logic [4:0] exp;
    logic       seen;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        va = 4'(ai); vb = 4'(bi);
        @(negedge clk);
        start4 = 1'b1; a4 = va; b4 = vb;
        sb4.push_back({va < vb, 4'(va - vb)});
        @(negedge clk);
        start4 = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
          if (done4) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        exp = sb4.pop_front();
        total_cnt++;
        if (!seen || {borrow4, diff4} !== exp)
          $display("FAIL w4 a=%0d b=%0d: seen=%b got diff=%h borrow=%b, want diff=%h borrow=%b",
                   ai, bi, seen, diff4, borrow4, exp[3:0], exp[4]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_sweep_w4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
